// File: rtl/ps2_key_sequencer.sv
// ---------------------------------------------------------------------------
// ps2_key_sequencer
//
// Drives the ps2_keyboard FIFO read handshake (kb_ready / kb_nextdata_n) and
// turns the raw scan byte stream into key events. E0 (extended) and F0
// (break) prefix bytes are folded into flags that qualify the next scan
// code. Each resulting key event is offered on a valid/ready interface. The
// block also tracks the currently held key and counts press events.
//
// A pending prefix flag that waits too long for its scan code is dropped and
// reported through a sticky error bit. A separate sticky bit records
// keyboard FIFO overflow.
//
// Optional feature:
//   TYPEMATIC_FILTER_EN  when defined, an auto-repeat press is dropped. An
//                        auto-repeat press is a press whose code and ext
//                        flag match the key already held. The byte is still
//                        popped and the prefix flags are still cleared.
//
// Parameters:
//   TIMEOUT_CYCLES  idle cycles after a prefix byte before the prefix drops
//   COUNT_W         width of press_count
//
// Ports:
//   clk            in   system clock
//   clrn           in   asynchronous active-low reset
//   kb_ready       in   keyboard FIFO non-empty
//   kb_data[7:0]   in   head-of-FIFO scan byte
//   kb_overflow    in   keyboard FIFO overflow
//   kb_nextdata_n  out  active-low FIFO pop, one-cycle pulse
//   ev_valid       out  key event available
//   ev_ready       in   consumer accepts event
//   ev_code[7:0]   out  scan code, prefix bytes stripped
//   ev_ext         out  event was E0-prefixed
//   ev_break       out  1 = release, 0 = press
//   held           out  a key is currently held
//   held_code[7:0] out  code of the held key (meaningful when held=1)
//   press_count    out  number of emitted press events, wraps
//   err_overflow   out  sticky: kb_overflow seen
//   err_prefix     out  sticky: a prefix timed out
//   clr_err        in   clears both sticky errors
// ---------------------------------------------------------------------------
module ps2_key_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned COUNT_W        = 8
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               kb_ready,
    input  logic [7:0]         kb_data,
    input  logic               kb_overflow,
    output logic               kb_nextdata_n,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic [7:0]         ev_code,
    output logic               ev_ext,
    output logic               ev_break,
    output logic               held,
    output logic [7:0]         held_code,
    output logic [COUNT_W-1:0] press_count,
    output logic               err_overflow,
    output logic               err_prefix,
    input  logic               clr_err
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_POP    = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               nextdata_n_q, nextdata_n_d;
    logic [7:0]         byte_q, byte_d;
    logic               ext_q, ext_d;
    logic               brk_q, brk_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               ev_valid_q, ev_valid_d;
    logic [7:0]         ev_code_q, ev_code_d;
    logic               ev_ext_q, ev_ext_d;
    logic               ev_break_q, ev_break_d;
    logic               held_q, held_d;
    logic [7:0]         held_code_q, held_code_d;
    logic               held_ext_q, held_ext_d;
    logic [COUNT_W-1:0] press_count_q, press_count_d;
    logic               err_overflow_q, err_overflow_d;
    logic               err_prefix_q, err_prefix_d;

    logic pop_go;
    logic is_press;
    logic held_match;
    logic drop;
    logic timeout_hit;

    always_comb begin
        state_d        = state_q;
        nextdata_n_d   = nextdata_n_q;
        byte_d         = byte_q;
        ext_d          = ext_q;
        brk_d          = brk_q;
        to_cnt_d       = to_cnt_q;
        ev_valid_d     = ev_valid_q;
        ev_code_d      = ev_code_q;
        ev_ext_d       = ev_ext_q;
        ev_break_d     = ev_break_q;
        held_d         = held_q;
        held_code_d    = held_code_q;
        held_ext_d     = held_ext_q;
        press_count_d  = press_count_q;
        timeout_hit    = 1'b0;
        drop           = 1'b0;

        // A pending event blocks popping; the keyboard FIFO holds the backlog.
        pop_go     = (state_q == S_IDLE) && kb_ready && !ev_valid_q;
        is_press   = !brk_q;
        held_match = held_q && (held_code_q == byte_q) && (held_ext_q == ext_q);

        if (ev_valid_q && ev_ready) begin
            ev_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (pop_go) begin
                    byte_d       = kb_data;
                    nextdata_n_d = 1'b0;
                    state_d      = S_POP;
                end
            end
            S_POP: begin
                nextdata_n_d = 1'b1;
                state_d      = S_SETTLE;
                if (byte_q == CODE_EXT) begin
                    ext_d = 1'b1;
                end else if (byte_q == CODE_BRK) begin
                    brk_d = 1'b1;
                end else begin
`ifdef TYPEMATIC_FILTER_EN
                    drop = is_press && held_match;
`else
                    drop = 1'b0;
`endif
                    if (!drop) begin
                        ev_valid_d = 1'b1;
                        ev_code_d  = byte_q;
                        ev_ext_d   = ext_q;
                        ev_break_d = brk_q;
                        if (is_press) begin
                            held_d        = 1'b1;
                            held_code_d   = byte_q;
                            held_ext_d    = ext_q;
                            press_count_d = press_count_q + COUNT_W'(1);
                        end else if (held_match) begin
                            held_d = 1'b0;
                        end
                    end
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            end
            // kb_ready needs one cycle after the pop before it is trustworthy.
            S_SETTLE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Prefix timeout: a pop in the same cycle takes precedence, so the
        // byte still decodes with its pending flags.
        if (pop_go) begin
            to_cnt_d = '0;
        end else if ((state_q == S_IDLE) && (ext_q || brk_q)) begin
            if (to_cnt_q == TO_LAST) begin
                timeout_hit = 1'b1;
                to_cnt_d    = '0;
                ext_d       = 1'b0;
                brk_d       = 1'b0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end else if (!(ext_q || brk_q)) begin
            to_cnt_d = '0;
        end

        // Sticky errors: a set beats a simultaneous clear.
        if (kb_overflow) begin
            err_overflow_d = 1'b1;
        end else if (clr_err) begin
            err_overflow_d = 1'b0;
        end else begin
            err_overflow_d = err_overflow_q;
        end

        if (timeout_hit) begin
            err_prefix_d = 1'b1;
        end else if (clr_err) begin
            err_prefix_d = 1'b0;
        end else begin
            err_prefix_d = err_prefix_q;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q        <= S_IDLE;
            nextdata_n_q   <= 1'b1;
            byte_q         <= '0;
            ext_q          <= 1'b0;
            brk_q          <= 1'b0;
            to_cnt_q       <= '0;
            ev_valid_q     <= 1'b0;
            ev_code_q      <= '0;
            ev_ext_q       <= 1'b0;
            ev_break_q     <= 1'b0;
            held_q         <= 1'b0;
            held_code_q    <= '0;
            held_ext_q     <= 1'b0;
            press_count_q  <= '0;
            err_overflow_q <= 1'b0;
            err_prefix_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            nextdata_n_q   <= nextdata_n_d;
            byte_q         <= byte_d;
            ext_q          <= ext_d;
            brk_q          <= brk_d;
            to_cnt_q       <= to_cnt_d;
            ev_valid_q     <= ev_valid_d;
            ev_code_q      <= ev_code_d;
            ev_ext_q       <= ev_ext_d;
            ev_break_q     <= ev_break_d;
            held_q         <= held_d;
            held_code_q    <= held_code_d;
            held_ext_q     <= held_ext_d;
            press_count_q  <= press_count_d;
            err_overflow_q <= err_overflow_d;
            err_prefix_q   <= err_prefix_d;
        end
    end

    assign kb_nextdata_n = nextdata_n_q;
    assign ev_valid      = ev_valid_q;
    assign ev_code       = ev_code_q;
    assign ev_ext        = ev_ext_q;
    assign ev_break      = ev_break_q;
    assign held          = held_q;
    assign held_code     = held_code_q;
    assign press_count   = press_count_q;
    assign err_overflow  = err_overflow_q;
    assign err_prefix    = err_prefix_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_sequencer
//
// Scoreboard bench. A keyboard FIFO model feeds bytes to the DUT. Each
// pushed byte runs through a byte-level reference model, and that model
// queues the expected key events. A monitor pops those expectations whenever
// an event is accepted. The same monitor also checks that a stalled event
// holds steady.
// ---------------------------------------------------------------------------
module tb_ps2_key_sequencer;

    localparam int TO_CYC = 16;

    logic       clk = 1'b0;
    logic       clrn;
    logic       kb_ready;
    logic [7:0] kb_data;
    logic       kb_overflow;
    logic       kb_nextdata_n;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       held;
    logic [7:0] held_code;
    logic [7:0] press_count;
    logic       err_overflow;
    logic       err_prefix;
    logic       clr_err;

    ps2_key_sequencer #(
        .TIMEOUT_CYCLES(TO_CYC),
        .COUNT_W       (8)
    ) dut (
        .clk          (clk),
        .clrn         (clrn),
        .kb_ready     (kb_ready),
        .kb_data      (kb_data),
        .kb_overflow  (kb_overflow),
        .kb_nextdata_n(kb_nextdata_n),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_code      (ev_code),
        .ev_ext       (ev_ext),
        .ev_break     (ev_break),
        .held         (held),
        .held_code    (held_code),
        .press_count  (press_count),
        .err_overflow (err_overflow),
        .err_prefix   (err_prefix),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- keyboard FIFO model ----------------
    logic [7:0] kb_mem [4096];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pops   = 0;

    assign kb_ready = (rd_ptr != wr_ptr);
    assign kb_data  = kb_mem[rd_ptr % 4096];

    // Pops on an active-low pulse; a reset flushes whatever is queued.
    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rd_ptr <= wr_ptr;
        end else if (!kb_nextdata_n && (rd_ptr != wr_ptr)) begin
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       held;
        logic [7:0] hcode;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    logic       m_ext = 1'b0, m_brk = 1'b0, m_held = 1'b0, m_hext = 1'b0;
    logic [7:0] m_hcode = 8'h00;
    logic [7:0] m_cnt = 8'h00;
    int         m_events = 0;

    task automatic model_byte(input logic [7:0] b);
        logic same;
        logic keep;
        exp_t e;
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            same = m_held && (m_hcode == b) && (m_hext == m_ext);
            keep = 1'b1;
`ifdef TYPEMATIC_FILTER_EN
            if (!m_brk && same) keep = 1'b0;
`endif
            if (keep) begin
                if (!m_brk) begin
                    m_held  = 1'b1;
                    m_hcode = b;
                    m_hext  = m_ext;
                    m_cnt   = m_cnt + 8'd1;
                end else if (same) begin
                    m_held = 1'b0;
                end
                e.code  = b;
                e.ext   = m_ext;
                e.brk   = m_brk;
                e.held  = m_held;
                e.hcode = m_hcode;
                e.cnt   = m_cnt;
                exp_q.push_back(e);
                m_events++;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_ext = 1'b0; m_brk = 1'b0; m_held = 1'b0; m_hext = 1'b0;
        m_hcode = 8'h00; m_cnt = 8'h00;
        exp_q.delete();
    endtask

    task automatic push_byte(input logic [7:0] b);
        kb_mem[wr_ptr % 4096] = b;
        wr_ptr++;
        model_byte(b);
    endtask

    // ---------------- consumer ready driver ----------------
    int ready_mode = 0; // 0: always ready, 1: never ready, 2: random

    initial begin
        ev_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ev_ready = 1'b1;
                1:       ev_ready = 1'b0;
                default: ev_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor ----------------
    int n_events = 0;

    initial begin
        logic       stall_chk;
        logic [7:0] s_code;
        logic       s_ext, s_brk;
        exp_t       e;
        stall_chk = 1'b0;
        s_code = 8'h00; s_ext = 1'b0; s_brk = 1'b0;
        forever begin
            @(negedge clk);
            if (stall_chk && clrn) begin
                chk("ev_stable", {ev_valid, ev_code, ev_ext, ev_break},
                    {1'b1, s_code, s_ext, s_brk});
            end
            stall_chk = 1'b0;
            if (clrn && ev_valid) begin
                if (ev_ready) begin
                    n_events++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_event: actual code=%0h ext=%0d brk=%0d required none",
                                 ev_code, ev_ext, ev_break);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ev_fields", {ev_code, ev_ext, ev_break}, {e.code, e.ext, e.brk});
                        chk("ev_held", held, e.held);
                        if (e.held) chk("ev_held_code", held_code, e.hcode);
                        chk("ev_press_count", press_count, e.cnt);
                    end
                end else begin
                    stall_chk = 1'b1;
                    s_code = ev_code;
                    s_ext  = ev_ext;
                    s_brk  = ev_break;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic drain(input string name);
        int n;
        n = 0;
        while ((wr_ptr != rd_ptr || exp_q.size() != 0 || ev_valid) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk({name, "_drain"}, 32'(n < 20000), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_nextdata_n"}, kb_nextdata_n, 1);
        chk({name, "_ev"}, {ev_valid, ev_code, ev_ext, ev_break}, 0);
        chk({name, "_held"}, {held, held_code}, 0);
        chk({name, "_press_count"}, press_count, 0);
        chk({name, "_errs"}, {err_overflow, err_prefix}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] codes [5] = '{8'h1C, 8'h32, 8'h21, 8'h75, 8'h6B};

    // ---------------- stimulus ----------------
    initial begin
        int ev0, p0, n_exp;
        logic [7:0] c0;
        clrn        = 1'b0;
        kb_overflow = 1'b0;
        clr_err     = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        clrn = 1'b1;
        repeat (2) @(negedge clk);

        // Single press: pop pulse one cycle after presentation, event one later.
        push_byte(8'h1C);
        @(negedge clk);
        chk("t1_pop_low", {kb_nextdata_n, ev_valid}, {1'b0, 1'b0});
        @(negedge clk);
        chk("t1_ev_valid", {kb_nextdata_n, ev_valid}, {1'b1, 1'b1});
        chk("t1_held", {held, held_code}, {1'b1, 8'h1C});
        chk("t1_press_count", press_count, 1);
        drain("t1");

        // Release then press/release: no event for the F0 byte.
        ev0 = n_events;
        push_byte(8'hF0); push_byte(8'h1C);
        push_byte(8'h1C); push_byte(8'hF0); push_byte(8'h1C);
        drain("t2");
        chk("t2_events", n_events - ev0, 3);
        chk("t2_held", held, 0);
        chk("t2_press_count", press_count, 2);

        // Extended press and release.
        ev0 = n_events;
        push_byte(8'hE0); push_byte(8'h75);
        push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75);
        drain("t3");
        chk("t3_events", n_events - ev0, 2);
        chk("t3_held", held, 0);

        // Backpressure: exactly one pop while ev_ready stays low.
        ready_mode = 1;
        repeat (2) @(negedge clk);
        p0 = pops;
        push_byte(8'h1C); push_byte(8'h32); push_byte(8'h21);
        repeat (22) @(negedge clk);
        chk("t4_one_pop", pops - p0, 1);
        chk("t4_holding", {ev_valid, ev_code, kb_ready}, {1'b1, 8'h1C, 1'b1});
        ready_mode = 0;
        drain("t4");
        chk("t4_all_popped", pops - p0, 3);

        // Auto-repeat presses.
        ev0 = n_events;
        c0  = m_cnt;
        push_byte(8'h1C); push_byte(8'h1C); push_byte(8'h1C);
        drain("t5");
`ifdef TYPEMATIC_FILTER_EN
        n_exp = 1;
`else
        n_exp = 3;
`endif
        chk("t5_events", n_events - ev0, n_exp);
        chk("t5_press_count", press_count, 32'(c0) + n_exp);

        // Random key traffic with random consumer stalls.
        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            int k;
            logic [7:0] c;
            k = $urandom_range(0, 6);
            c = codes[$urandom_range(0, 4)];
            repeat ($urandom_range(0, 5)) @(negedge clk);
            case (k)
                0, 1: push_byte(c);
                2: begin push_byte(8'hE0); push_byte(c); end
                3: begin push_byte(8'hF0); push_byte(c); end
                4: begin push_byte(8'hE0); push_byte(8'hF0); push_byte(c); end
                5: begin push_byte(8'hF0); push_byte(8'hE0); push_byte(c); end
                default: begin
                    push_byte(8'hE0); push_byte(8'hE0);
                    push_byte(8'hF0); push_byte(8'hF0); push_byte(c);
                end
            endcase
        end
        drain("rand");
        ready_mode = 0;
        chk("rand_events", n_events, m_events);
        chk("rand_no_prefix_err", err_prefix, 0);

        // press_count wraps past 255.
        for (int i = 0; i < 260; i++) push_byte((i % 2 == 0) ? 8'h1C : 8'h32);
        drain("wrap");
        chk("wrap_press_count", press_count, m_cnt);

        // Prefix timeout, then a plain code decodes without the stale flag.
        push_byte(8'hE0);
        repeat (10) @(negedge clk);
        chk("t6_no_early_timeout", err_prefix, 0);
        repeat (20) @(negedge clk);
        chk("t6_timeout", err_prefix, 1);
        m_ext = 1'b0;
        m_brk = 1'b0;
        push_byte(8'h75);
        drain("t6");

        // Sticky overflow, clear, and set-beats-clear.
        kb_overflow = 1'b1;
        @(negedge clk);
        kb_overflow = 1'b0;
        @(negedge clk);
        chk("t6_errs_set", {err_overflow, err_prefix}, 2'b11);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
        chk("t6_errs_clr", {err_overflow, err_prefix}, 2'b00);
        kb_overflow = 1'b1;
        clr_err     = 1'b1;
        @(negedge clk);
        kb_overflow = 1'b0;
        clr_err     = 1'b0;
        @(negedge clk);
        chk("t6_set_wins", err_overflow, 1);

        // Asynchronous reset in the middle of a pop.
        push_byte(8'h1C);
        @(negedge clk);
        chk("t6_in_pop", kb_nextdata_n, 0);
        clrn = 1'b0;
        #1;
        model_reset();
        chk_reset_outputs("midpop_reset");
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_reset_quiet", {ev_valid, kb_ready}, 2'b00);
        push_byte(8'h32);
        drain("post_reset");
        chk("post_reset_count", {held, held_code, press_count}, {1'b1, 8'h32, 8'd1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
